// File: rtl/adder_defs_pkg.sv
// Shared state encoding and sizing helpers
// for the serial adder/subtractor.
package adder_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_slice_nbit.sv
// N-bit combinational ripple-carry slice
// built from per-bit full adders.
module adder_slice_nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];
  // carry into the top bit; the top level xors it
  // with cout to form signed overflow
  assign cmsb = c[N-1];

endmodule

// File: rtl/addsub_serial_nbit.sv
// Multi-cycle add/sub: SLICE bits per clock through
// one shared ripple slice, with Z/N/V/C and saturation.
module addsub_serial_nbit
  import adder_defs::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             sat_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = idx_w(NSLICE);
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  state_e state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             sat_q;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_s;
  logic             sl_co;
  logic             sl_cm;
  logic [WIDTH-1:0] raw_d;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;

  assign sl_a = a_q[int'(idx_q)*SLICE +: SLICE];
  assign sl_b = b_q[int'(idx_q)*SLICE +: SLICE];

  adder_slice_nbit #(
    .N(SLICE)
  ) u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .cin (carry_q),
    .s   (sl_s),
    .cout(sl_co),
    .cmsb(sl_cm)
  );

  // new slice enters at the top; after NSLICE
  // shifts the register holds the full raw sum
  if (NSLICE > 1) begin : g_shift
    assign raw_d = {sl_s, acc_q[WIDTH-1:SLICE]};
  end else begin : g_single
    assign raw_d = sl_s;
  end

  assign ovf_d = sl_co ^ sl_cm;

  always_comb begin
    res_d = raw_d;
    if (sat_q && ovf_d)
      res_d = {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            sat_q   <= sat_en;
            carry_q <= sub;
            idx_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q   <= raw_d;
          carry_q <= sl_co;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            result  <= res_d;
            cout    <= sl_co;
            ovf     <= ovf_d;
            zero    <= (res_d == '0);
            neg     <= res_d[WIDTH-1];
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = (state_q != RUN);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_addsub_serial_nbit.sv
// Randomised and directed bench for addsub_serial_nbit
// against an arithmetic reference model.
module tb_addsub_serial_nbit;

  localparam int W = 16;
  localparam int S = 4;
  localparam int NS = W / S;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic         sat_en;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         neg;

  int n_chk = 0;
  int n_pass = 0;

  addsub_serial_nbit #(
    .WIDTH(W),
    .SLICE(S)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .sat_en(sat_en),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .result(result),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero),
    .neg   (neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // {result, cout, ovf, zero, neg}
  function automatic logic [19:0] model(
    input logic [15:0] x, input logic [15:0] y,
    input logic s, input logic sat);
    int unsigned ux, uy;
    int sx, sy, ideal;
    logic [15:0] r;
    logic c, v;
    ux = x; uy = y;
    sx = $signed(x); sy = $signed(y);
    if (s) begin
      ideal = sx - sy;
      c = (ux >= uy);
      r = x - y;
    end else begin
      ideal = sx + sy;
      c = (ux + uy) > 65535;
      r = x + y;
    end
    v = (ideal > 32767) || (ideal < -32768);
    if (sat && v) r = (ideal > 0) ? 16'h7FFF : 16'h8000;
    return {r, c, v, (r == 16'h0), r[15]};
  endfunction

  function automatic logic [19:0] outs();
    return {result, cout, ovf, zero, neg};
  endfunction

  // start at next edge, scramble inputs while running;
  // glitch=1 pulses start during RUN
  task automatic run_op(input string tag,
                        input logic [15:0] x, input logic [15:0] y,
                        input logic s, input logic sat,
                        input bit glitch);
    logic [19:0] exp;
    int n;
    exp = model(x, y, s, sat);
    @(negedge clk);
    a = x; b = y; sub = s; sat_en = sat; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, {30'b0, busy, ready}, 32'h2);
    n = 0;
    while (!done && n < 20) begin
      a = 16'($urandom); b = 16'($urandom);
      sub = 1'($urandom); sat_en = 1'($urandom);
      start = glitch && (n == 1);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, n, NS);
    chk({tag, "_out"}, outs(), exp);
    @(negedge clk);
    chk({tag, "_hold"}, {done, ready, outs()}, {2'b01, exp});
  endtask

  initial begin
    logic [19:0] e1, e2;
    int n;
    rst = 1'b1; start = 1'b0; sub = 1'b0; sat_en = 1'b0;
    a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", {busy, ready, done, outs()}, {3'b010, 20'h0});
    rst = 1'b0;

    run_op("add",   16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    run_op("ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("satp",  16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    run_op("subz",  16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0);
    run_op("satn",  16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
    run_op("wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("bneg",  16'h0000, 16'h8000, 1'b1, 1'b1, 1'b0);
    run_op("glitch", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 30; i++)
      run_op("rnd", 16'($urandom), 16'($urandom),
             1'($urandom), 1'($urandom), 1'b0);

    // start held through DONE: second op follows immediately
    e1 = model(16'h1111, 16'h2222, 1'b0, 1'b0);
    e2 = model(16'h9000, 16'h7000, 1'b1, 1'b1);
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; sat_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("b2b_lat1", n, NS);
    chk("b2b_out1", outs(), e1);
    a = 16'h9000; b = 16'h7000; sub = 1'b1; sat_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("b2b_lat2", n, NS + 1);
    chk("b2b_out2", outs(), e2);

    // reset at the second RUN edge aborts the op
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; sub = 1'b0; sat_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_clr", {busy, ready, done, outs()}, {3'b010, 20'h0});
    n = 0;
    repeat (NS + 2) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_nodone", n, 0);
    run_op("after", 16'h0101, 16'h0202, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
